// File: rtl/lighting_pkg.sv
// Shared fixed-point vector types and constants for the shading-stage lighting units.
package lighting_pkg;
    localparam int FXP_W    = 32;
    localparam int FXP_FRAC = 16;
    localparam logic [FXP_W-1:0] FXP_ONE = 32'h0001_0000;
    localparam int DIFFUSE_MULTI_LAT = 5;

    typedef logic [3*FXP_W-1:0] vec3_t;

    // Component index 0 = x (MSB slice), 2 = z (LSB slice)
    function automatic logic [FXP_W-1:0] vec3_get(input vec3_t v, input int idx);
        return v[(2-idx)*FXP_W +: FXP_W];
    endfunction

    function automatic vec3_t vec3_pack(input logic [FXP_W-1:0] x, input logic [FXP_W-1:0] y,
                                        input logic [FXP_W-1:0] z);
        return {x, y, z};
    endfunction
endpackage

// File: rtl/fxp_mul.sv
// Registered signed fixed-point multiply: full product, arithmetic shift by FRAC, keep low W bits.
module fxp_mul #(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p_q
);
    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] prod_sh;
    logic [W-1:0] p_d;

    always_comb begin
        prod    = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        prod_sh = prod >>> FRAC;
        p_d     = p_q;
        if (en) p_d = prod_sh[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_q <= '0;
        else        p_q <= p_d;
    end
endmodule

// File: rtl/lightning_diffuse_multi.sv
// Multi-light Lambertian diffuse accumulator: sum_k max(0,N.L_k)*(lc_k*dc) per hit, clamped output.
module lightning_diffuse_multi
    import lighting_pkg::*;
#(
    parameter int W         = 32,
    parameter int FRAC      = 16,
    parameter int ACC_GUARD = 4,
    parameter int CLAMP_ONE = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             light_valid,
    output logic             light_ready,
    input  logic             light_last,
    input  logic [3*W-1:0]   hit_diffuse_color,
    input  logic [3*W-1:0]   hit_normal,
    input  logic [3*W-1:0]   light_color,
    input  logic [3*W-1:0]   to_light,
    output logic [3*W-1:0]   diffuse_component,
    output logic [CNT_W-1:0] light_count,
    output logic             out_valid,
    input  logic             out_ready
);
    // Tagged registers S0..S3; S4 consumes the S3 products combinationally
    localparam int NV = DIFFUSE_MULTI_LAT - 1;
    localparam int AW = W + ACC_GUARD;
    localparam logic [AW-1:0] UPPER = (CLAMP_ONE != 0) ? (AW'(1) << FRAC)
                                                       : {{(ACC_GUARD+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    logic stall, s4_vld, s4_last, s4_first, s4_load;

    logic [NV-1:0] vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d, first_pipe_q, first_pipe_d;
    logic first_q, first_d;

    logic [2:0][W-1:0] dc_q, dc_d, n_q, n_d, l_q, l_d, lc_q, lc_d;
    logic [2:0][W-1:0] nl_p, cc_p, term_p;
    logic [2:0][W-1:0] cc2_q, cc2_d;
    logic [W-1:0]      dot_q, dot_d;
    logic signed [W+1:0] dot_sum;

    logic [2:0][AW-1:0] acc_q, acc_d, sum;
    logic [2:0][AW:0]   wide;
    logic [2:0][AW-1:0] term_ext;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;

    logic [2:0][W-1:0] dcomp_q, dcomp_d;
    logic [CNT_W-1:0]  lcount_q, lcount_d;
    logic              ovalid_q, ovalid_d;

    assign s4_vld   = vld_pipe_q[NV-1];
    assign s4_last  = last_pipe_q[NV-1];
    assign s4_first = first_pipe_q[NV-1];
    assign stall    = ovalid_q && !out_ready && s4_vld && s4_last;
    assign s4_load  = s4_vld && !stall;

    assign light_ready       = !stall;
    assign diffuse_component = dcomp_q;
    assign light_count       = lcount_q;
    assign out_valid         = ovalid_q;

    // S1 and S3 multipliers share the global hold
    for (genvar i = 0; i < 3; i++) begin : g_mul
        fxp_mul #(.W(W), .FRAC(FRAC)) u_nl (
            .clk(clk), .rst_n(rst_n), .en(!stall), .a(n_q[i]), .b(l_q[i]), .p_q(nl_p[i]));
        fxp_mul #(.W(W), .FRAC(FRAC)) u_cc (
            .clk(clk), .rst_n(rst_n), .en(!stall), .a(lc_q[i]), .b(dc_q[i]), .p_q(cc_p[i]));
        fxp_mul #(.W(W), .FRAC(FRAC)) u_term (
            .clk(clk), .rst_n(rst_n), .en(!stall), .a(cc2_q[i]), .b(dot_q), .p_q(term_p[i]));
    end

    always_comb begin
        dot_sum = $signed({{2{nl_p[0][W-1]}}, nl_p[0]}) + $signed({{2{nl_p[1][W-1]}}, nl_p[1]})
                + $signed({{2{nl_p[2][W-1]}}, nl_p[2]});

        vld_pipe_d   = vld_pipe_q;
        last_pipe_d  = last_pipe_q;
        first_pipe_d = first_pipe_q;
        first_d      = first_q;
        dc_d  = dc_q;
        n_d   = n_q;
        l_d   = l_q;
        lc_d  = lc_q;
        dot_d = dot_q;
        cc2_d = cc2_q;
        if (!stall) begin
            vld_pipe_d   = {vld_pipe_q[NV-2:0], light_valid};
            last_pipe_d  = {last_pipe_q[NV-2:0], light_last};
            first_pipe_d = {first_pipe_q[NV-2:0], first_q};
            if (light_valid) first_d = light_last;
            dc_d  = hit_diffuse_color;
            n_d   = hit_normal;
            l_d   = to_light;
            lc_d  = light_color;
            dot_d = dot_sum[W+1] ? '0 : dot_sum[W-1:0];
            cc2_d = cc_p;
        end
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dcomp_d  = dcomp_q;
        lcount_d = lcount_q;
        ovalid_d = ovalid_q && !out_ready;
        cnt_nxt  = s4_first ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
        for (int i = 0; i < 3; i++) begin
            term_ext[i] = {{ACC_GUARD{term_p[i][W-1]}}, term_p[i]};
            wide[i]     = {acc_q[i][AW-1], acc_q[i]} + {term_ext[i][AW-1], term_ext[i]};
            if (s4_first)                      sum[i] = term_ext[i];
            else if (wide[i][AW] != wide[i][AW-1]) sum[i] = wide[i][AW] ? ACC_MIN : ACC_MAX;
            else                               sum[i] = wide[i][AW-1:0];
        end
        if (s4_load) begin
            acc_d = sum;
            cnt_d = cnt_nxt;
            if (s4_last) begin
                ovalid_d = 1'b1;
                lcount_d = cnt_nxt;
                for (int i = 0; i < 3; i++) begin
                    if (sum[i][AW-1])        dcomp_d[i] = '0;
                    else if (sum[i] > UPPER) dcomp_d[i] = UPPER[W-1:0];
                    else                     dcomp_d[i] = sum[i][W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q   <= '0;
            last_pipe_q  <= '0;
            first_pipe_q <= '0;
            first_q      <= 1'b1;
            dc_q  <= '0;
            n_q   <= '0;
            l_q   <= '0;
            lc_q  <= '0;
            dot_q <= '0;
            cc2_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            dcomp_q  <= '0;
            lcount_q <= '0;
            ovalid_q <= 1'b0;
        end else begin
            vld_pipe_q   <= vld_pipe_d;
            last_pipe_q  <= last_pipe_d;
            first_pipe_q <= first_pipe_d;
            first_q      <= first_d;
            dc_q  <= dc_d;
            n_q   <= n_d;
            l_q   <= l_d;
            lc_q  <= lc_d;
            dot_q <= dot_d;
            cc2_q <= cc2_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            dcomp_q  <= dcomp_d;
            lcount_q <= lcount_d;
            ovalid_q <= ovalid_d;
        end
    end
endmodule

// File: tb/tb_lightning_diffuse_multi.sv
// Directed bench for lightning_diffuse_multi: one instance per clamp mode, shared stimulus.
module tb_lightning_diffuse_multi;
    localparam int W = 32;
    localparam logic [W-1:0] ONE  = 32'h0001_0000;
    localparam logic [W-1:0] HALF = 32'h0000_8000;
    localparam logic [W-1:0] QTR  = 32'h0000_4000;
    localparam logic [W-1:0] TQ   = 32'h0000_C000;
    localparam logic [W-1:0] NEG1 = 32'hFFFF_0000;
    localparam logic [W-1:0] Z    = 32'h0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic light_valid = 1'b0, light_last = 1'b0, out_ready = 1'b1;
    logic [3*W-1:0] hit_diffuse_color = '0, hit_normal = '0, light_color = '0, to_light = '0;
    logic [3*W-1:0] dcomp1, dcomp0;
    logic [7:0] cnt1, cnt0;
    logic ov1, ov0, lr1, lr0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lightning_diffuse_multi #(.CLAMP_ONE(1)) dut (
        .clk(clk), .rst_n(rst_n), .light_valid(light_valid), .light_ready(lr1),
        .light_last(light_last), .hit_diffuse_color(hit_diffuse_color), .hit_normal(hit_normal),
        .light_color(light_color), .to_light(to_light), .diffuse_component(dcomp1),
        .light_count(cnt1), .out_valid(ov1), .out_ready(out_ready));

    lightning_diffuse_multi #(.CLAMP_ONE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .light_valid(light_valid), .light_ready(lr0),
        .light_last(light_last), .hit_diffuse_color(hit_diffuse_color), .hit_normal(hit_normal),
        .light_color(light_color), .to_light(to_light), .diffuse_component(dcomp0),
        .light_count(cnt0), .out_valid(ov0), .out_ready(out_ready));

    function automatic logic [3*W-1:0] v3(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] z);
        return {x, y, z};
    endfunction

    task automatic chk(input string tag, input logic [3*W-1:0] got, input logic [3*W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one beat for one cycle; returns #1 after the accepting edge
    task automatic beat(input logic [3*W-1:0] n, input logic [3*W-1:0] l,
                        input logic [3*W-1:0] lc, input logic [3*W-1:0] dc, input logic last);
        light_valid = 1'b1; light_last = last;
        hit_normal = n; to_light = l; light_color = lc; hit_diffuse_color = dc;
        @(posedge clk); #1;
        light_valid = 1'b0; light_last = 1'b0;
    endtask

    // Called right after the last beat's accepting edge, with out_ready=1
    task automatic expect_out(input string tag, input logic [3*W-1:0] exp1,
                              input logic [3*W-1:0] exp0, input logic [7:0] ecnt);
        repeat (3) @(posedge clk);
        #1 chk({tag, " early_valid"}, {95'd0, ov1}, 96'd0);
        @(posedge clk); #1;
        chk({tag, " valid"}, {95'd0, ov1}, 96'd1);
        chk({tag, " color"}, dcomp1, exp1);
        chk({tag, " color_unclamped"}, dcomp0, exp0);
        chk({tag, " count"}, {88'd0, cnt1}, {88'd0, ecnt});
        @(posedge clk); #1;
        chk({tag, " valid_drop"}, {95'd0, ov1}, 96'd0);
    endtask

    initial begin
        #12;
        chk("rst out_valid", {95'd0, ov1}, 96'd0);
        chk("rst color", dcomp1, 96'd0);
        chk("rst count", {88'd0, cnt1}, 96'd0);
        chk("rst ready", {95'd0, lr1}, 96'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        beat(v3(Z, Z, ONE), v3(Z, Z, ONE), v3(ONE, ONE, ONE), v3(HALF, QTR, ONE), 1'b1);
        expect_out("single", v3(HALF, QTR, ONE), v3(HALF, QTR, ONE), 8'd1);

        beat(v3(Z, Z, ONE), v3(Z, Z, HALF), v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), 1'b0);
        beat(v3(Z, Z, ONE), v3(Z, Z, HALF), v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), 1'b1);
        expect_out("two", v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), 8'd2);

        beat(v3(Z, Z, ONE), v3(Z, Z, NEG1), v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), 1'b1);
        expect_out("backface", 96'd0, 96'd0, 8'd1);

        beat(v3(Z, Z, ONE), v3(Z, Z, TQ), v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), 1'b0);
        beat(v3(Z, Z, ONE), v3(Z, Z, TQ), v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), 1'b0);
        beat(v3(Z, Z, ONE), v3(Z, Z, TQ), v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), 1'b1);
        expect_out("clamp", v3(ONE, ONE, ONE),
                   v3(32'h0002_4000, 32'h0002_4000, 32'h0002_4000), 8'd3);

        // Backpressure: A then B back-to-back while the output is blocked
        out_ready = 1'b0;
        beat(v3(Z, Z, ONE), v3(Z, Z, ONE), v3(ONE, ONE, ONE), v3(HALF, QTR, ONE), 1'b1);
        beat(v3(Z, Z, ONE), v3(Z, Z, HALF), v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp A valid", {95'd0, ov1}, 96'd1);
        chk("bp A color", dcomp1, v3(HALF, QTR, ONE));
        chk("bp stall ready", {95'd0, lr1}, 96'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp A held", dcomp1, v3(HALF, QTR, ONE));
        chk("bp A held valid", {95'd0, ov1}, 96'd1);
        chk("bp still stalled", {95'd0, lr1}, 96'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp B valid", {95'd0, ov1}, 96'd1);
        chk("bp B color", dcomp1, v3(HALF, HALF, HALF));
        chk("bp B count", {88'd0, cnt1}, 96'd1);
        chk("bp ready back", {95'd0, lr1}, 96'd1);
        @(posedge clk); #1;
        chk("bp B drained", {95'd0, ov1}, 96'd0);

        // Reset mid-hit discards the partial sum
        beat(v3(Z, Z, ONE), v3(Z, Z, ONE), v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), 1'b0);
        beat(v3(Z, Z, ONE), v3(Z, Z, ONE), v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst valid", {95'd0, ov1}, 96'd0);
        chk("midrst color", dcomp1, 96'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        beat(v3(Z, Z, ONE), v3(Z, Z, ONE), v3(ONE, ONE, ONE), v3(QTR, HALF, QTR), 1'b1);
        expect_out("after_rst", v3(QTR, HALF, QTR), v3(QTR, HALF, QTR), 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lightning_diffuse_multi.md
# lightning_diffuse_multi

Parametrised multi-light Lambertian diffuse unit for the shading stage. For one hit point it accumulates `sum_k max(0, N·L_k) * (light_color_k ⊙ diffuse_color)` over a stream of light beats. Output channels are clamped to a non-negative range. Each accumulated colour is emitted with a valid/ready handshake. The unit sits between the light-iteration logic and the colour combiner, and accepts one light per cycle at full throughput.

## Interface
Parameters:
- `W`, 32: fixed-point component width, signed two's complement.
- `FRAC`, 16: fractional bits. Default format is Q16.16, so 1.0 = 0x00010000.
- `ACC_GUARD`, 4: extra integer bits in the accumulator.
- `CLAMP_ONE`, 1: 1 clamps each output channel to [0, 1.0]; 0 clamps to [0, 2^(W-1)-1].
- `CNT_W`, 8: width of the light counter.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `light_valid`  in  1  light beat present.
- `light_ready`  out  1  beat accepted when `light_valid && light_ready`.
- `light_last`  in  1  final light of the current hit.
- `hit_diffuse_color`  in  3W  material colour. Sampled on every beat; the source holds it constant across a hit.
- `hit_normal`  in  3W  unit normal.
- `light_color`  in  3W  colour of this light.
- `to_light`  in  3W  unit vector toward this light.
- `diffuse_component`  out  3W  accumulated, clamped colour.
- `light_count`  out  CNT_W  number of beats accumulated into this result.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.

Vector packing is x = [3W-1:2W], y = [2W-1:W], z = [W-1:0].

## Operation
- Internal `first` flag is 1 after reset and after every accepted `light_last` beat. It is carried down the pipeline together with `last`.
- Fixed-point multiply: full 2W-bit signed product, arithmetic right shift by FRAC (truncates toward −inf), keep the low W bits.
- S0 registers the inputs and the first/last tags.
- S1 computes the 6 products: `n_i*l_i` and `lc_i*dc_i`.
- S2 computes dot = sum of `n_i*l_i`. A negative dot is forced to 0.
- S3 computes each colour product multiplied by dot.
- S4 accumulates, with width W+ACC_GUARD and signed saturation.
  - On a `first` beat: acc = term and cnt = 1.
  - Otherwise: acc += term and cnt += 1. cnt saturates at 2^CNT_W-1.
- On a `last` beat at S4, the output register loads clamp(acc + term) and cnt.
  - A negative channel becomes 0.
  - Upper bound is 1.0 if CLAMP_ONE, else the W-bit positive maximum.
- A single beat with `light_last`=1 is a complete one-light hit.

## Timing
- Reset values: `out_valid`=0, `diffuse_component`=0, `light_count`=0, `light_ready`=1, all pipeline valids 0, accumulator 0, `first`=1.
- Latency: a `light_last` beat accepted at cycle t gives `out_valid`=1 at t+5 when there is no stall.
- Throughput: 1 beat/cycle. Beats of the next hit may follow a `last` beat immediately.
- Stall condition: `stall = out_valid && !out_ready && (S4 holds a valid last beat)`.
  - While stalled, all stages hold and `light_ready`=0.
  - A beat offered during a stall is not accepted.
- If the output register is drained and a last beat reloads it in the same cycle, the load happens with no stall and no bubble.
- `diffuse_component` and `light_count` stay stable while `out_valid && !out_ready`.
- Reset asserted mid-hit discards the partial sum and all in-flight beats. The first beat after reset starts a new hit.

## Structure
- Shared package `lighting_pkg` holds:
  - `vec3_t` typedef (3×W packed);
  - `FXP_ONE`;
  - component extract/pack helpers;
  - the stage count `DIFFUSE_MULTI_LAT = 5`.
- Sub-module `fxp_mul`: registered W×W signed multiply with FRAC shift. It is instantiated 9 times: 6 in S1 and 3 in S3.
- The accumulator, clamp and handshake logic stay in the top module.

## Test plan
- **Single light.** N=(0,0,1.0), L=(0,0,1.0), light=(1.0,1.0,1.0), diffuse=(0.5,0.25,1.0), last=1 → at t+5 output = (0x8000, 0x4000, 0x10000), `light_count`=1.
- **Two lights.** dot=0.5 each, light=(1.0,1.0,1.0), diffuse=(1.0,1.0,1.0), two back-to-back beats → output = (0x10000 ×3), `light_count`=2, one `out_valid` pulse.
- **Back-facing light.** N=(0,0,1.0), L=(0,0,-1.0) → output (0,0,0), `light_count`=1.
- **Clamp.** Three lights each contributing 0.75 per channel:
  - CLAMP_ONE=1 → 0x10000 per channel;
  - CLAMP_ONE=0 → 0x24000 per channel.
- **Backpressure.** Hold `out_ready`=0, send hits A and B (one beat each) back-to-back.
  - A appears and is held stable.
  - `light_ready` drops when B's last beat reaches S4.
  - After `out_ready`=1, B appears on the next cycle; order is A then B.
- **Reset mid-hit.** Accept 2 non-last beats, assert `rst_n`=0 for 1 cycle, then send one full single-beat hit → output equals that beat alone, `light_count`=1, no stale `out_valid`.
